// File: rtl/coh_pkg.sv
// Shared types for the L1 coherence (snoop) bus arbiter.
// Bus ops, line address layout and arbiter FSM states.
package coh_pkg;

    localparam int OFF_W = 8;
    localparam int SET_W = 6;
    localparam int TAG_W = 18;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_WB   = 2'd3
    } bus_op_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [SET_W-1:0] set;
        logic [OFF_W-1:0] offset;
    } address_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GRANT    = 3'd1,
        ST_SNOOP    = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_MEM      = 3'd4,
        ST_COMPLETE = 3'd5
    } arb_state_e;

    // Clear the byte offset so the bus always carries a line address.
    function automatic address_t line_align(input address_t a);
        address_t r;
        r        = a;
        r.offset = '0;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after the base pointer.
// Purely combinational; the owner keeps the pointer.
module rr_arbiter
    import coh_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_base,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int w_j;

    // Scan from the farthest slot back to the base so the nearest wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = (int'(i_base) + k) % N;
            if (i_req[w_j]) begin
                o_idx   = IDX_W'(w_j);
                o_valid = 1'b1;
            end
        end
        if (o_valid) begin
            o_gnt = N'(1) << o_idx;
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Coherence bus arbiter: grant, snoop broadcast, hit collection,
// then memory or cache-to-cache fill; one transaction at a time.
module snoop_bus_arbiter
    import coh_pkg::*;
#(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_W     = 32,
    parameter int SNOOP_TMO  = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CACHES-1:0]        req,
    input  logic [NUM_CACHES*2-1:0]      req_op,
    input  logic [NUM_CACHES*ADDR_W-1:0] req_addr,
    output logic [NUM_CACHES-1:0]        gnt,
    output logic                         bus_valid,
    output logic [1:0]                   bus_op,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [2:0]                   bus_src,
    input  logic [NUM_CACHES-1:0]        snoop_done,
    input  logic [NUM_CACHES-1:0]        snoop_hit,
    input  logic [NUM_CACHES-1:0]        snoop_hitm,
    input  logic                         flush_done,
    output logic                         mem_req,
    output logic                         mem_we,
    input  logic                         mem_ready,
    output logic [NUM_CACHES-1:0]        done,
    output logic                         resp_shared,
    output logic                         resp_c2c
);

    localparam int TMO_W = $clog2(SNOOP_TMO + 1);

    arb_state_e            r_state;
    arb_state_e            w_state_nx;
    logic [IDX_W-1:0]      r_rr;
    logic [IDX_W-1:0]      r_src;
    bus_op_e               r_op;
    logic [ADDR_W-1:0]     r_addr;
    logic [NUM_CACHES-1:0] r_done_acc;
    logic [NUM_CACHES-1:0] r_hit;
    logic [NUM_CACHES-1:0] r_hitm;
    logic [TMO_W-1:0]      r_tmo;
    logic                  r_shared;
    logic                  r_c2c;

    logic [NUM_CACHES-1:0] w_gnt_oh;
    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_win_vld;
    bus_op_e               w_win_op;
    logic [ADDR_W-1:0]     w_win_addr;
    logic [NUM_CACHES-1:0] w_mask;
    logic [NUM_CACHES-1:0] w_done_acc;
    logic [NUM_CACHES-1:0] w_hit_acc;
    logic [NUM_CACHES-1:0] w_hitm_acc;
    logic                  w_all_done;
    logic                  w_tmo;
    logic                  w_snoop_exit;

    rr_arbiter #(
        .N (NUM_CACHES)
    ) u_rr (
        .i_req   (req),
        .i_base  (r_rr),
        .o_gnt   (w_gnt_oh),
        .o_idx   (w_win_idx),
        .o_valid (w_win_vld)
    );

    assign w_win_op   = bus_op_e'(req_op[2*w_win_idx +: 2]);
    assign w_win_addr = req_addr[ADDR_W*w_win_idx +: ADDR_W];

    // Owner never snoops its own request.
    assign w_mask     = ~(NUM_CACHES'(1) << r_src);
    assign w_done_acc = r_done_acc | (snoop_done & w_mask);
    assign w_hit_acc  = r_hit  | (snoop_hit  & snoop_done & w_mask);
    assign w_hitm_acc = r_hitm | (snoop_hitm & snoop_done & w_mask);

    // Exit on the sticky (registered) set so every answer gets a cycle.
    assign w_all_done   = &(r_done_acc | ~w_mask);
    assign w_tmo        = (r_tmo == TMO_W'(SNOOP_TMO - 1));
    assign w_snoop_exit = w_all_done | w_tmo;

    assign bus_op   = r_op;
    assign bus_addr = r_addr;
    assign bus_src  = r_src;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Latch the winner's request and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr   <= '0;
            r_src  <= '0;
            r_op   <= BUS_RD;
            r_addr <= '0;
        end else if (r_state == ST_GRANT && w_win_vld) begin
            r_rr   <= (w_win_idx == IDX_W'(NUM_CACHES - 1)) ?
                      '0 : w_win_idx + 1'b1;
            r_src  <= w_win_idx;
            r_op   <= w_win_op;
            r_addr <= {w_win_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        end
    end

    // Sticky snoop answers and the saturating snoop timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_acc <= '0;
            r_hit      <= '0;
            r_hitm     <= '0;
            r_tmo      <= '0;
        end else if (r_state == ST_GRANT) begin
            r_done_acc <= '0;
            r_hit      <= '0;
            r_hitm     <= '0;
            r_tmo      <= '0;
        end else if (r_state == ST_SNOOP) begin
            r_done_acc <= w_done_acc;
            r_hit      <= w_hit_acc;
            r_hitm     <= w_hitm_acc;
            if (r_tmo != TMO_W'(SNOOP_TMO)) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // Response flags handed back with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shared <= 1'b0;
            r_c2c    <= 1'b0;
        end else if (r_state == ST_GRANT) begin
            r_shared <= 1'b0;
            r_c2c    <= 1'b0;
        end else if (r_state == ST_SNOOP && w_snoop_exit) begin
            r_shared <= (|w_hit_acc) && (r_op == BUS_RD);
            r_c2c    <= 1'b0;
        end else if (r_state == ST_FLUSH && flush_done) begin
            r_shared <= (r_op == BUS_RD);
            r_c2c    <= 1'b1;
        end
    end

    // Next state and bus/memory/completion outputs.
    always_comb begin
        w_state_nx  = r_state;
        gnt         = '0;
        bus_valid   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        done        = '0;
        resp_shared = 1'b0;
        resp_c2c    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nx = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt = w_gnt_oh;
                if (!w_win_vld) begin
                    w_state_nx = ST_IDLE;
                end else if (w_win_op == BUS_WB) begin
                    w_state_nx = ST_MEM;
                end else begin
                    w_state_nx = ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                bus_valid = 1'b1;
                if (w_snoop_exit) begin
                    if (|w_hitm_acc) begin
                        w_state_nx = ST_FLUSH;
                    end else if (r_op == BUS_UPGR) begin
                        w_state_nx = ST_COMPLETE;
                    end else begin
                        w_state_nx = ST_MEM;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_done) begin
                    w_state_nx = ST_COMPLETE;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_op == BUS_WB);
                if (mem_ready) begin
                    w_state_nx = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                done        = NUM_CACHES'(1) << r_src;
                resp_shared = r_shared;
                resp_c2c    = r_c2c;
                w_state_nx  = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

`ifndef SYNTHESIS
    // Two modified owners is a protocol error; resolution treats it as one.
    always @(posedge clk) begin
        if (rst_n && r_state == ST_SNOOP && w_snoop_exit &&
            $countones(w_hitm_acc) > 1) begin
            $error("snoop_bus_arbiter: multiple hitM snoopers");
        end
    end
`endif

endmodule
